// File: rtl/cs_pkg.sv
// Shared defaults, FSM encoding and the compare-count helper for the CS stream driver.
package cs_pkg;

    localparam int N_PAT_DEF = 2000;
    localparam int WIN_DEF   = 9;
    localparam int LAT_DEF   = 1;
    localparam int XW_DEF    = 8;
    localparam int YW_DEF    = 10;
    localparam int AW_DEF    = 15;
    localparam int EW_DEF    = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FEED  = 3'd1;
    localparam state_t S_RUN   = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    // Number of full windows in a stream of n_pat samples.
    function automatic int n_cmp(input int n_pat, input int win);
        return n_pat - win + 1;
    endfunction

endpackage

// File: rtl/cs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module cs_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, or step unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cs_stream_driver.sv
// Streams samples into CS and checks its Y output against a golden memory.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | after reset, waiting for start
//  FEED    | loading the first WIN samples (window not yet full)
//  RUN     | loading remaining samples, compares may be running
//  DRAIN   | all samples loaded, waiting out the last LAT compares
//  DONE    | result held (done/pass/err_cnt) until the next start
module cs_stream_driver
    import cs_pkg::*;
#(
    parameter int N_PAT = N_PAT_DEF,
    parameter int WIN   = WIN_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int XW    = XW_DEF,
    parameter int YW    = YW_DEF,
    parameter int AW    = AW_DEF,
    parameter int EW    = EW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] x_addr,
    input  logic [XW-1:0] x_data,
    output logic [XW-1:0] X,
    input  logic [YW-1:0] Y,
    output logic [AW-1:0] gold_addr,
    input  logic [YW-1:0] gold_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [EW-1:0] err_cnt,
    output logic          mis_pulse,
    output logic [AW-1:0] mis_idx
);

    localparam int            N_CMP    = n_cmp(N_PAT, WIN);
    localparam logic [AW-1:0] WIN_LAST = AW'(WIN - 1);
    localparam logic [AW-1:0] XI_LAST  = AW'(N_PAT - 1);
    localparam logic [AW-1:0] CI_LAST  = AW'(N_CMP - 1);

    if (N_PAT < WIN) begin : g_npat_chk
        $error("cs_stream_driver: N_PAT must be >= WIN");
    end
    if (LAT < 1) begin : g_lat_chk
        $error("cs_stream_driver: LAT must be >= 1");
    end
    if ((2 ** AW) <= N_PAT) begin : g_aw_chk
        $error("cs_stream_driver: AW too narrow for N_PAT");
    end

    state_t          state_q, state_d;
    logic [AW-1:0]   xi_q, xi_d;
    logic [XW-1:0]   x_q, x_d;
    logic [AW-1:0]   ci_q, ci_d;
    logic [LAT-1:0]  sh_q, sh_d;
    logic            cmp_en_q, cmp_en_d;
    logic            done_q, done_d;
    logic            mis_pulse_q, mis_pulse_d;
    logic [AW-1:0]   mis_idx_q, mis_idx_d;

    logic feeding, start_ok, last_x, win_ld, mismatch, last_cmp;

    assign feeding  = (state_q == S_FEED) || (state_q == S_RUN);
    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_x   = feeding && (xi_q == XI_LAST);
    assign win_ld   = (state_q == S_FEED) && (xi_q == WIN_LAST);
    assign mismatch = cmp_en_q && (Y != gold_data);
    assign last_cmp = cmp_en_q && (ci_q == CI_LAST);

    // Sequencing and datapath next-state; start only lands in IDLE/DONE.
    always_comb begin
        state_d     = state_q;
        xi_d        = xi_q;
        x_d         = x_q;
        ci_d        = ci_q;
        sh_d        = (sh_q << 1) | LAT'(win_ld);
        cmp_en_d    = cmp_en_q;
        done_d      = done_q;
        mis_pulse_d = mismatch;
        mis_idx_d   = mis_idx_q;

        unique case (state_q)
            S_IDLE:  if (start) state_d = S_FEED;
            S_FEED:  if (win_ld) state_d = last_x ? S_DRAIN : S_RUN;
            S_RUN:   if (last_x) state_d = S_DRAIN;
            S_DRAIN: if (last_cmp) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_FEED;
            default: state_d = S_IDLE;
        endcase

        // x_addr parks on the last sample once it has been loaded.
        if (feeding) begin
            x_d = x_data;
            if (!last_x) xi_d = xi_q + AW'(1);
        end

        // The compare window opens after the LAT-deep delay and closes on the last index.
        if (sh_q[LAT-1])   cmp_en_d = 1'b1;
        else if (last_cmp) cmp_en_d = 1'b0;

        if (cmp_en_q) ci_d = ci_q + AW'(1);
        if (mismatch) mis_idx_d = ci_q;
        if (last_cmp) done_d = 1'b1;

        if (start_ok) begin
            xi_d        = '0;
            ci_d        = '0;
            sh_d        = '0;
            cmp_en_d    = 1'b0;
            done_d      = 1'b0;
            mis_pulse_d = 1'b0;
            mis_idx_d   = '0;
        end
    end

    // State registers; reset aborts any run immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            xi_q        <= '0;
            x_q         <= '0;
            ci_q        <= '0;
            sh_q        <= '0;
            cmp_en_q    <= 1'b0;
            done_q      <= 1'b0;
            mis_pulse_q <= 1'b0;
            mis_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            xi_q        <= xi_d;
            x_q         <= x_d;
            ci_q        <= ci_d;
            sh_q        <= sh_d;
            cmp_en_q    <= cmp_en_d;
            done_q      <= done_d;
            mis_pulse_q <= mis_pulse_d;
            mis_idx_q   <= mis_idx_d;
        end
    end

    cs_sat_counter #(.W(EW)) u_err_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (start_ok),
        .inc_i  (mismatch),
        .cnt_o  (err_cnt)
    );

    assign x_addr    = xi_q;
    assign X         = x_q;
    assign gold_addr = ci_q;
    assign busy      = feeding || (state_q == S_DRAIN);
    assign done      = done_q;
    assign pass      = done_q && (err_cnt == '0);
    assign mis_pulse = mis_pulse_q;
    assign mis_idx   = mis_idx_q;

endmodule
